// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration register bank.
package i2c_cfg_pkg;

  localparam int unsigned I2C_BYTE_BITS = 8;
  localparam int unsigned NREG_DEFAULT  = 13;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StMack
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_filter.sv
// Pad conditioning: 2-flop synchronizer, 3-sample majority filter, registered edge strobes.
module i2c_sync_filter (
  input  logic sysclk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;
  logic       filt_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;
  logic       maj;

  assign maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

  // Flops reset to 1 so an idle (pulled-up) bus produces no edges out of reset.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      hist_q  <= 2'b11;
      filt_q  <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pad};
      hist_q  <= {hist_q[0], sync_q[1]};
      filt_q  <= maj;
      level_q <= filt_q;
      rise_q  <= filt_q & ~level_q;
      fall_q  <= ~filt_q & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_cfg_regbank.sv
// I2C slave holding a bank of 8-bit configuration registers with an auto-incrementing pointer.
module i2c_cfg_regbank
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR = 7'h50,
  parameter int unsigned NREG     = NREG_DEFAULT,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_oe,
  output logic [NREG*I2C_BYTE_BITS-1:0] regs_o,
  output logic                          cfg_update,
  output logic                          busy
);

  localparam int unsigned BW = I2C_BYTE_BITS;
  localparam int unsigned PW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_filter u_scl (
    .sysclk (sysclk),
    .rst    (rst),
    .pad    (scl_i),
    .level  (scl_lvl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_filter u_sda (
    .sysclk (sysclk),
    .rst    (rst),
    .pad    (sda_i),
    .level  (sda_lvl),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  i2c_state_t    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [BW-2:0] sh_q, sh_d;
  logic [BW-2:0] tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ptr_ok_q, ptr_ok_d;
  logic          rw_q, rw_d;
  logic          mack_nack_q, mack_nack_d;
  logic          wr_flag_q, wr_flag_d;
  logic          busy_q, busy_d;
  logic          cfg_q, cfg_d;
  logic          pend_q, pend_d;
  logic          hold_act_q, hold_act_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          oe_q, oe_d;
  logic [BW-1:0] regs_q [NREG];

  logic [BW-1:0] rx_byte;
  logic [PW-1:0] ptr_inc;
  logic          last_bit;
  logic          reg_we;
  logic          drive;

  assign rx_byte  = {sh_q, sda_lvl};
  assign ptr_inc  = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + PW'(1);
  assign last_bit = (cnt_q == 3'(BW - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    ptr_ok_d    = ptr_ok_q;
    rw_d        = rw_q;
    mack_nack_d = mack_nack_q;
    wr_flag_d   = wr_flag_q;
    busy_d      = busy_q;
    cfg_d       = 1'b0;
    pend_d      = pend_q;
    hold_act_d  = hold_act_q;
    hold_cnt_d  = hold_cnt_q;
    oe_d        = oe_q;
    reg_we      = 1'b0;
    drive       = 1'b0;

    // SDA only moves once the hold window after an SCL fall has elapsed.
    if (hold_act_q) begin
      if (hold_cnt_q == HW'(1)) begin
        oe_d       = pend_q;
        hold_act_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - HW'(1);
      end
    end

    if (scl_lvl && sda_fall) begin
      state_d    = StAddr;
      cnt_d      = '0;
      wr_flag_d  = 1'b0;
      busy_d     = 1'b1;
      hold_act_d = 1'b0;
      oe_d       = 1'b0;
    end else if (scl_lvl && sda_rise) begin
      state_d    = StIdle;
      cfg_d      = wr_flag_q;
      wr_flag_d  = 1'b0;
      busy_d     = 1'b0;
      hold_act_d = 1'b0;
      oe_d       = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          sh_d  = rx_byte[BW-2:0];
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              rw_d    = sda_lvl;
              state_d = (rx_byte[BW-1:1] == I2C_ADDR) ? StAddrAck : StIdle;
            end else if (state_q == StPtr) begin
              state_d  = StPtrAck;
              ptr_ok_d = 32'(rx_byte) < NREG;
              if (32'(rx_byte) < NREG) ptr_d = rx_byte[PW-1:0];
            end else begin
              state_d   = StWdataAck;
              reg_we    = 1'b1;
              ptr_d     = ptr_inc;
              wr_flag_d = 1'b1;
            end
          end
        end
        StRdata: begin
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = StMack;
          end
        end
        StMack: begin
          cnt_d       = 3'd1;
          mack_nack_d = sda_lvl;
          ptr_d       = ptr_inc;
        end
        StAddrAck, StPtrAck, StWdataAck: cnt_d = 3'd1;
        default: ;
      endcase
    end else if (scl_fall) begin
      // cnt==0 in an ACK state marks the fall that opens the 9th bit; cnt==1 the one closing it.
      case (state_q)
        StAddrAck: begin
          if (cnt_q == 3'd0) begin
            drive = 1'b1;
          end else begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = StRdata;
              tx_d    = regs_q[ptr_q][BW-2:0];
              drive   = ~regs_q[ptr_q][BW-1];
            end else begin
              state_d = StPtr;
            end
          end
        end
        StPtrAck: begin
          if (cnt_q == 3'd0) begin
            drive = ptr_ok_q;
          end else begin
            cnt_d   = '0;
            state_d = ptr_ok_q ? StWdata : StIdle;
          end
        end
        StWdataAck: begin
          if (cnt_q == 3'd0) begin
            drive = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = StWdata;
          end
        end
        StRdata: begin
          tx_d  = {tx_q[BW-3:0], 1'b0};
          drive = ~tx_q[BW-2];
        end
        StMack: begin
          if (cnt_q != 3'd0) begin
            cnt_d = '0;
            if (mack_nack_q) begin
              state_d = StIdle;
            end else begin
              state_d = StRdata;
              tx_d    = regs_q[ptr_q][BW-2:0];
              drive   = ~regs_q[ptr_q][BW-1];
            end
          end
        end
        default: ;
      endcase
      pend_d     = drive;
      hold_act_d = 1'b1;
      hold_cnt_d = HW'(HOLD_CYC - 1);
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      ptr_ok_q    <= 1'b0;
      rw_q        <= 1'b0;
      mack_nack_q <= 1'b0;
      wr_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_q       <= 1'b0;
      pend_q      <= 1'b0;
      hold_act_q  <= 1'b0;
      hold_cnt_q  <= '0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      ptr_ok_q    <= ptr_ok_d;
      rw_q        <= rw_d;
      mack_nack_q <= mack_nack_d;
      wr_flag_q   <= wr_flag_d;
      busy_q      <= busy_d;
      cfg_q       <= cfg_d;
      pend_q      <= pend_d;
      hold_act_q  <= hold_act_d;
      hold_cnt_q  <= hold_cnt_d;
      oe_q        <= oe_d;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_regs
    assign regs_o[k*BW +: BW] = regs_q[k];
  end

  assign sda_oe     = oe_q;
  assign cfg_update = cfg_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_cfg_regbank.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA against the register bank.
module tb_i2c_cfg_regbank;

  localparam int unsigned NREG = 13;
  localparam int unsigned RW   = NREG * 8;
  localparam int          Q    = 100;  // quarter SCL period: 10 sysclk cycles

  logic          sysclk = 1'b0;
  logic          rst    = 1'b1;
  logic          scl_m  = 1'b1;
  logic          sda_m  = 1'b1;
  logic          sda_oe;
  logic          cfg_update;
  logic          busy;
  logic [RW-1:0] regs_o;
  logic          sda_bus;

  int total = 0;
  int bad   = 0;
  int cfg_cyc = 0;
  int oe_cyc  = 0;
  int oe_hi_chg = 0;
  logic oe_prev = 1'b0;

  int            base_cfg;
  int            base_oe;
  logic          ack;
  logic          smp;
  logic [7:0]    rd;
  logic [RW-1:0] exp_regs;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 sysclk = ~sysclk;

  i2c_cfg_regbank #(
    .I2C_ADDR (7'h50),
    .NREG     (NREG),
    .HOLD_CYC (4)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .regs_o     (regs_o),
    .cfg_update (cfg_update),
    .busy       (busy)
  );

  always @(negedge sysclk) begin
    if (cfg_update) cfg_cyc <= cfg_cyc + 1;
    if (sda_oe) oe_cyc <= oe_cyc + 1;
    if (rst && scl_m && (sda_oe !== oe_prev)) oe_hi_chg <= oe_hi_chg + 1;
    oe_prev <= sda_oe;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b, output logic s);
    #(Q) sda_m = b;
    #(Q) scl_m = 1'b1;
    #(Q) s = sda_bus;
    #(Q) scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, s);
    a = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    bit_out(~m_ack, s);
  endtask

  task automatic start_c();
    #(Q) sda_m = 1'b1;
    #(Q) scl_m = 1'b1;
    #(2*Q) sda_m = 1'b0;
    #(2*Q) scl_m = 1'b0;
  endtask

  task automatic stop_c();
    #(Q) sda_m = 1'b0;
    #(Q) scl_m = 1'b1;
    #(2*Q) sda_m = 1'b1;
    #(2*Q);
  endtask

  initial begin
    #1 rst = 1'b0;
    #50;
    check("reset_sda_oe", 128'(sda_oe), 128'(1'b0));
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_cfg_update", 128'(cfg_update), 128'(1'b0));
    check("reset_regs", 128'(regs_o), 128'(0));
    rst = 1'b1;
    #(4*Q);

    // Basic write: ptr 0, two data bytes.
    base_cfg = cfg_cyc;
    start_c();
    check("t1_busy_start", 128'(busy), 128'(1'b1));
    send_byte(8'hA0, ack); check("t1_ack_addr", 128'(ack), 128'(1'b1));
    send_byte(8'h00, ack); check("t1_ack_ptr", 128'(ack), 128'(1'b1));
    send_byte(8'h11, ack); check("t1_ack_d0", 128'(ack), 128'(1'b1));
    send_byte(8'h22, ack); check("t1_ack_d1", 128'(ack), 128'(1'b1));
    stop_c();
    check("t1_reg0", 128'(regs_o[7:0]), 128'(8'h11));
    check("t1_reg1", 128'(regs_o[15:8]), 128'(8'h22));
    check("t1_cfg_pulse", 128'(cfg_cyc - base_cfg), 128'(1));
    check("t1_busy_stop", 128'(busy), 128'(1'b0));

    // Pointer wrap from 12 to 0.
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h0C, ack);
    send_byte(8'h33, ack);
    send_byte(8'h44, ack); check("t2_ack_d1", 128'(ack), 128'(1'b1));
    stop_c();
    check("t2_reg12", 128'(regs_o[103:96]), 128'(8'h33));
    check("t2_reg0_wrap", 128'(regs_o[7:0]), 128'(8'h44));
    check("t2_reg1_kept", 128'(regs_o[15:8]), 128'(8'h22));
    check("t2_cfg_pulse", 128'(cfg_cyc - base_cfg), 128'(1));

    // Write reg5, re-point to 5, repeated START into a read of two bytes.
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    send_byte(8'h5A, ack); check("t3_ack_wr", 128'(ack), 128'(1'b1));
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack); check("t3_ack_ptr", 128'(ack), 128'(1'b1));
    start_c();
    send_byte(8'hA1, ack); check("t3_ack_rd_addr", 128'(ack), 128'(1'b1));
    read_byte(1'b1, rd); check("t3_rd0", 128'(rd), 128'(8'h5A));
    read_byte(1'b0, rd); check("t3_rd1", 128'(rd), 128'(8'h00));
    stop_c();
    check("t3_no_cfg", 128'(cfg_cyc - base_cfg), 128'(0));
    check("t3_reg5", 128'(regs_o[47:40]), 128'(8'h5A));

    exp_regs = '0;
    exp_regs[7:0]    = 8'h44;
    exp_regs[15:8]   = 8'h22;
    exp_regs[47:40]  = 8'h5A;
    exp_regs[103:96] = 8'h33;

    // Foreign address: never driven, busy still tracks the bus.
    base_cfg = cfg_cyc;
    base_oe  = oe_cyc;
    start_c();
    check("t4_busy_start", 128'(busy), 128'(1'b1));
    send_byte(8'hA2, ack); check("t4_nack_addr", 128'(ack), 128'(1'b0));
    send_byte(8'h55, ack);
    stop_c();
    check("t4_oe_never", 128'(oe_cyc - base_oe), 128'(0));
    check("t4_busy_stop", 128'(busy), 128'(1'b0));
    check("t4_regs", 128'(regs_o), 128'(exp_regs));
    check("t4_no_cfg", 128'(cfg_cyc - base_cfg), 128'(0));

    // Out-of-range pointer is NACKed and following bytes ignored.
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h0D, ack); check("t5_nack_ptr", 128'(ack), 128'(1'b0));
    send_byte(8'h99, ack); check("t5_nack_after", 128'(ack), 128'(1'b0));
    stop_c();
    check("t5_regs", 128'(regs_o), 128'(exp_regs));
    check("t5_no_cfg", 128'(cfg_cyc - base_cfg), 128'(0));

    // STOP after four data bits leaves the target register alone.
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) bit_out(1'b1, smp);
    stop_c();
    check("t6_partial_regs", 128'(regs_o), 128'(exp_regs));
    check("t6_partial_oe", 128'(sda_oe), 128'(1'b0));
    check("t6_partial_no_cfg", 128'(cfg_cyc - base_cfg), 128'(0));

    // Reset mid-byte.
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    bit_out(1'b1, smp);
    bit_out(1'b0, smp);
    bit_out(1'b1, smp);
    #(Q) rst = 1'b0;
    #1;
    check("t6_rst_oe", 128'(sda_oe), 128'(1'b0));
    check("t6_rst_busy", 128'(busy), 128'(1'b0));
    check("t6_rst_regs", 128'(regs_o), 128'(0));
    #(Q) rst = 1'b1;
    stop_c();

    // Post-reset writes, then a read that relies on the persisted pointer.
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA0, ack); check("t7_ack_addr", 128'(ack), 128'(1'b1));
    send_byte(8'h0C, ack);
    send_byte(8'hC3, ack);
    send_byte(8'hD4, ack);
    stop_c();
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h0B, ack);
    send_byte(8'hE1, ack);
    stop_c();
    check("t7_cfg_pulses", 128'(cfg_cyc - base_cfg), 128'(2));
    exp_regs = '0;
    exp_regs[7:0]    = 8'hD4;
    exp_regs[95:88]  = 8'hE1;
    exp_regs[103:96] = 8'hC3;
    check("t7_regs", 128'(regs_o), 128'(exp_regs));
    base_cfg = cfg_cyc;
    start_c();
    send_byte(8'hA1, ack);
    read_byte(1'b1, rd); check("t7_rd_ptr12", 128'(rd), 128'(8'hC3));
    read_byte(1'b0, rd); check("t7_rd_wrap0", 128'(rd), 128'(8'hD4));
    stop_c();
    check("t7_rd_no_cfg", 128'(cfg_cyc - base_cfg), 128'(0));

    check("oe_stable_scl_high", 128'(oe_hi_chg), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
